// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, framing bits and keyboard
// command bytes. Also imported by the keyboard receive path.
package ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INHIBIT   = 3'd1;
    localparam state_t ST_RTS       = 3'd2;
    localparam state_t ST_SEND      = 3'd3;
    localparam state_t ST_WAIT_IDLE = 3'd4;
    localparam state_t ST_DONE      = 3'd5;
    localparam state_t ST_ERR       = 3'd6;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    // Bits shifted out after the start bit: data LSB first, odd parity, stop.
    localparam int FRAME_W = 10;

    // The fall that drives the stop bit; the next fall is the device ACK.
    localparam logic [3:0] STOP_FALL = 4'd10;

    function automatic logic [FRAME_W-1:0] tx_frame(input logic [7:0] data);
        return {STOP_BIT, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// single-cycle falling-edge pulse on the synchronized clock.
module ps2_line_sync (
    input  logic pclk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_s1_q, clk_s1_d;
    logic clk_s2_q, clk_s2_d;
    logic clk_prev_q, clk_prev_d;
    logic data_s1_q, data_s1_d;
    logic data_s2_q, data_s2_d;

    always_comb begin
        clk_s1_d   = clk_in;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        data_s1_d  = data_in;
        data_s2_d  = data_s1_q;
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a phantom fall.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value, so the chain really is two stages deep.
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
        end
    end

    assign clk_sync  = clk_s2_q;
    assign data_sync = data_s2_q;
    assign clk_fall  = clk_prev_q & ~clk_s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked
// out by the device on its falling edges, then ACK check and bus-idle wait.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int START_TIMEOUT  = 975000,
    parameter int PACKET_TIMEOUT = 130000,
    parameter int CNT_W          = 20
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LIM    = CNT_W'(START_TIMEOUT);
    localparam logic [CNT_W-1:0] PACKET_LIM   = CNT_W'(PACKET_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .pclk      (pclk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]         edge_n_q, edge_n_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               accept;

    assign accept  = tx_valid && (state_q == ST_IDLE);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no branch below
        // can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_inc;
        edge_n_d  = edge_n_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = tx_frame(tx_data);
                    edge_n_d  = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                end
            end

            // Device falls are ignored here: our pull-down owns the clock line.
            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    state_d   = ST_RTS;
                    clk_oe_d  = 1'b0;
                    data_oe_d = ~START_BIT;
                    cnt_d     = '0;
                end
            end

            ST_RTS: begin
                if (cnt_q == START_LIM) begin
                    state_d = ST_ERR;
                end else if (clk_fall) begin
                    state_d   = ST_SEND;
                    edge_n_d  = 4'd1;
                    data_oe_d = ~shift_q[0];
                    shift_d   = {STOP_BIT, shift_q[FRAME_W-1:1]};
                    cnt_d     = '0;
                end
            end

            // Each fall presents the next bit while the device holds clock low;
            // the fall after the stop bit is the ACK sample point.
            ST_SEND: begin
                if (cnt_q == PACKET_LIM) begin
                    state_d = ST_ERR;
                end else if (clk_fall) begin
                    edge_n_d = edge_n_q + 4'd1;
                    if (edge_n_q == STOP_FALL) begin
                        state_d = data_sync ? ST_ERR : ST_WAIT_IDLE;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {STOP_BIT, shift_q[FRAME_W-1:1]};
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (cnt_q == PACKET_LIM) begin
                    state_d = ST_ERR;
                end else if (clk_sync && data_sync) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE, ST_ERR: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                edge_n_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Any abort lets go of both lines in the same edge that enters ERR.
        if (state_d == ST_ERR || state_d == ST_DONE || state_d == ST_IDLE) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end
        if (accept) begin
            clk_oe_d = 1'b1;
        end
    end

    // Line enables are flops on the async reset, so rst releases the bus at
    // once rather than at the next pclk edge.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_n_q  <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_n_q  <= edge_n_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign tx_busy     = ~tx_ready;
    assign tx_done     = (state_q == ST_DONE);
    assign tx_err      = (state_q == ST_ERR);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the
// host; frame and done/err monitors pop expectations queued by the stimulus.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 10;
    localparam int START_TO = 200;
    localparam int PACKET_TO = 2000;

    typedef enum logic [1:0] {DEV_ACK, DEV_NACK, DEV_SILENT} dev_mode_t;

    logic       pclk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_line, ps2_data_line;

    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       dev_active   = 1'b0;
    logic       dev_abort    = 1'b0;
    logic       dev_clk_prev = 1'b1;
    int         dev_falls    = 0;
    dev_mode_t  dev_mode     = DEV_ACK;
    int         oe_run       = 0;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] exp_frame_q[$];
    bit          exp_res_q[$];   // 1 = tx_done expected, 0 = tx_err expected

    assign ps2_clk_line  = !(ps2_clk_oe  || dev_clk_low);
    assign ps2_data_line = !(ps2_data_oe || dev_data_low);

    always #5 pclk = ~pclk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .START_TIMEOUT  (START_TO),
        .PACKET_TIMEOUT (PACKET_TO),
        .CNT_W          (20)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device: 40-cycle clock, samples the line on each rising edge.
    task automatic dev_frame();
        logic [11:0] got;
        bit aborted;
        got = '0;
        aborted = 0;
        dev_active = 1'b1;
        repeat (10) @(negedge pclk);
        got[0] = ps2_data_line;
        for (int i = 1; i <= 11; i++) begin
            if (dev_abort) begin
                aborted = 1;
                break;
            end
            dev_clk_low = 1'b1;
            dev_falls = i;
            repeat (20) @(negedge pclk);
            dev_clk_low = 1'b0;
            if (i <= 10) got[i] = ps2_data_line;
            if (i == 10 && dev_mode == DEV_ACK) begin
                repeat (5) @(negedge pclk);
                dev_data_low = 1'b1;
                repeat (15) @(negedge pclk);
            end else begin
                repeat (20) @(negedge pclk);
            end
        end
        repeat (5) @(negedge pclk);
        dev_data_low = 1'b0;
        dev_clk_low = 1'b0;
        if (!aborted) begin
            if (exp_frame_q.size() == 0) check("frame_unexpected", exp_frame_q.size(), 1);
            else check("frame_bits", {21'd0, got[10:0]}, {21'd0, exp_frame_q.pop_front()});
        end
        dev_falls = 0;
        dev_active = 1'b0;
    endtask

    // RTS is the clock line coming back high while data is held low.
    initial begin
        forever begin
            @(negedge pclk);
            if (rst && !dev_clk_prev && ps2_clk_line && !ps2_data_line && dev_mode != DEV_SILENT)
                dev_frame();
            dev_clk_prev = ps2_clk_line;
        end
    end

    // Result monitor: every done/err pulse must match the next queued outcome.
    initial begin
        forever begin
            @(negedge pclk);
            if (rst && (tx_done || tx_err)) begin
                check("done_err_exclusive", {31'd0, tx_done & tx_err}, 0);
                if (exp_res_q.size() == 0) check("unexpected_pulse", {30'd0, tx_done, tx_err}, 0);
                else check("result", {30'd0, tx_done, tx_err}, exp_res_q.pop_front() ? 2 : 1);
            end
        end
    end

    // Inhibit monitor: every clk_oe pulse lasts exactly INHIBIT cycles.
    initial begin
        forever begin
            @(negedge pclk);
            if (!rst) oe_run = 0;
            else if (ps2_clk_oe) oe_run++;
            else if (oe_run != 0) begin
                check("inhibit_len", oe_run, INHIBIT);
                oe_run = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check("ready_before_send", {31'd0, tx_ready}, 1);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        tx_data = 8'h00;
        check("busy_after_accept", {29'd0, tx_ready, tx_busy, ps2_clk_oe}, 3'b011);
    endtask

    task automatic wait_result(output bit got_done);
        int n;
        n = 0;
        got_done = 0;
        while (!(tx_done || tx_err) && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        check("result_seen", {31'd0, tx_done | tx_err}, 1);
        got_done = tx_done;
    endtask

    task automatic wait_dev_idle();
        int n;
        n = 0;
        while (dev_active && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("device_idle", {31'd0, dev_active}, 0);
        repeat (5) @(negedge pclk);
    endtask

    task automatic wait_falls(input int target);
        int n;
        n = 0;
        while (dev_falls < target && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        check("wait_falls", dev_falls, target);
    endtask

    initial begin
        bit got_done;
        int lat;

        rst = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge pclk);
        check("reset_outputs",
              {26'd0, tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 6'b100000);
        rst = 1'b1;
        repeat (3) @(negedge pclk);

        // 1: 0xED with ACK
        exp_frame_q.push_back(11'b1_1_11101101_0);
        exp_res_q.push_back(1'b1);
        send(CMD_SET_LED);
        wait_result(got_done);
        check("t1_done", {31'd0, got_done}, 1);
        wait_dev_idle();

        // 2: 0xF4 with ACK; ready returns right after the done pulse
        exp_frame_q.push_back(11'b1_0_11110100_0);
        exp_res_q.push_back(1'b1);
        send(CMD_ENABLE);
        wait_result(got_done);
        @(negedge pclk);
        check("t2_ready_after_done", {30'd0, tx_ready, tx_busy}, 2'b10);
        wait_dev_idle();

        // 3: device leaves data high at the ACK fall
        dev_mode = DEV_NACK;
        exp_frame_q.push_back(11'b1_1_11111111_0);
        exp_res_q.push_back(1'b0);
        send(CMD_RESET);
        wait_result(got_done);
        check("t3_err_lines", {29'd0, got_done, ps2_clk_oe, ps2_data_oe}, 0);
        wait_dev_idle();

        // 4: device never clocks; start timeout measured from data_oe rising
        dev_mode = DEV_SILENT;
        exp_res_q.push_back(1'b0);
        send(CMD_ENABLE);
        lat = 0;
        while (!ps2_data_oe && lat < 50) begin
            @(negedge pclk);
            lat++;
        end
        check("t4_rts_seen", {31'd0, ps2_data_oe}, 1);
        lat = 0;
        while (!tx_err && lat < 400) begin
            @(negedge pclk);
            lat++;
        end
        check("t4_timeout_window", {31'd0, (lat >= START_TO) && (lat <= START_TO + 2)}, 1);
        check("t4_err_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        repeat (5) @(negedge pclk);
        dev_mode = DEV_ACK;

        // 5: async reset while bit 4 (a 0) is on the line
        send(CMD_SET_LED);
        wait_falls(5);
        repeat (8) @(negedge pclk);
        check("t5_bit4_driven", {31'd0, ps2_data_oe}, 1);
        #2 rst = 1'b0;
        dev_abort = 1'b1;
        #1 check("t5_async_release", {29'd0, ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        wait_dev_idle();
        dev_abort = 1'b0;
        repeat (50) @(negedge pclk);
        check("t5_idle_after_reset", {31'd0, tx_ready}, 1);

        // 6: request while busy is dropped; the latched byte is kept
        exp_frame_q.push_back(11'b1_1_11101101_0);
        exp_res_q.push_back(1'b1);
        send(CMD_SET_LED);
        wait_falls(3);
        tx_data = CMD_RESET;
        tx_valid = 1'b1;
        check("t6_not_ready", {31'd0, tx_ready}, 0);
        @(negedge pclk);
        tx_valid = 1'b0;
        tx_data = 8'h00;
        wait_result(got_done);
        check("t6_first_done", {31'd0, got_done}, 1);
        wait_dev_idle();
        exp_frame_q.push_back(11'b1_1_11111111_0);
        exp_res_q.push_back(1'b1);
        send(CMD_RESET);
        wait_result(got_done);
        check("t6_second_done", {31'd0, got_done}, 1);
        wait_dev_idle();
        repeat (20) @(negedge pclk);

        check("frames_left", exp_frame_q.size(), 0);
        check("results_left", exp_res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
